// File: rtl/game_pkg.sv
// Shared definitions for the game sequencer and the pixel mux.
package game_pkg;

  typedef enum logic [2:0] {
    GS_IDLE    = 3'd0,
    GS_PLAY    = 3'd1,
    GS_DYING   = 3'd2,
    GS_RESPAWN = 3'd3,
    GS_OVER    = 3'd4,
    GS_WON     = 3'd5
  } game_state_e;

  localparam int unsigned DEF_LIVES    = 3;
  localparam logic [11:0] DEATH_COLOUR = 12'h0F0;

endpackage

// File: rtl/frame_tick_gen.sv
// One-cycle pulse on each falling edge of the active-low vSync.
module frame_tick_gen (
  input  logic sys_clk,
  input  logic Reset,
  input  logic vSync,
  output logic frame_tick
);

  logic vsync_q;

  always_ff @(posedge sys_clk or posedge Reset) begin
    if (Reset) begin
      vsync_q <= 1'b1;
    end else begin
      vsync_q <= vSync;
    end
  end

  assign frame_tick = vsync_q & ~vSync;

endmodule

// File: rtl/game_flow_ctrl.sv
// Game sequencer: lives, death/respawn timing and win/lose flags, all timed in video frames.
module game_flow_ctrl
  import game_pkg::*;
#(
  parameter int unsigned LIVES          = DEF_LIVES,
  parameter int unsigned DEATH_FRAMES   = 60,
  parameter int unsigned RESPAWN_FRAMES = 30,
  parameter int unsigned INVULN_FRAMES  = 90,
  parameter int unsigned FLASH_SHIFT    = 3
) (
  input  logic       sys_clk,
  input  logic       Reset,
  input  logic       vSync,
  input  logic       start_pulse,
  input  logic       death_signal,
  input  logic [5:0] enemy_alive,
  output logic       play_en,
  output logic       respawn,
  output logic [1:0] lives,
  output logic       flash,
  output logic       game_over,
  output logic       game_won,
  output logic [2:0] state
);

  localparam logic [1:0] LivesInit   = 2'(LIVES);
  localparam logic [7:0] DeathLast   = 8'(DEATH_FRAMES - 1);
  localparam logic [7:0] RespawnLast = 8'(RESPAWN_FRAMES - 1);
  localparam logic [7:0] InvulnInit  = 8'(INVULN_FRAMES);

  logic frame_tick;

  frame_tick_gen u_frame_tick_gen (
    .sys_clk    (sys_clk),
    .Reset      (Reset),
    .vSync      (vSync),
    .frame_tick (frame_tick)
  );

  game_state_e state_q, state_d;
  logic [7:0]  frame_cnt_q, frame_cnt_d;
  logic [7:0]  invuln_q, invuln_d;
  logic [1:0]  lives_q, lives_d;
  logic        respawn_d;

  always_comb begin
    state_d   = state_q;
    lives_d   = lives_q;
    invuln_d  = invuln_q;
    respawn_d = 1'b0;

    unique case (state_q)
      GS_IDLE: begin
        lives_d  = LivesInit;
        invuln_d = 8'd0;
        if (start_pulse) begin
          state_d   = GS_PLAY;
          respawn_d = 1'b1;
        end
      end
      GS_PLAY: begin
        if (frame_tick && invuln_q != 8'd0) begin
          invuln_d = invuln_q - 8'd1;
        end
        // Death wins over clearing the last enemy in the same cycle.
        if (death_signal && invuln_q == 8'd0) begin
          state_d = GS_DYING;
          lives_d = (lives_q == 2'd0) ? 2'd0 : lives_q - 2'd1;
        end else if (enemy_alive == 6'b0) begin
          state_d = GS_WON;
        end
      end
      GS_DYING: begin
        if (frame_tick && frame_cnt_q == DeathLast) begin
          if (lives_q == 2'd0) begin
            state_d = GS_OVER;
          end else begin
            state_d   = GS_RESPAWN;
            respawn_d = 1'b1;
          end
        end
      end
      GS_RESPAWN: begin
        if (frame_tick && frame_cnt_q == RespawnLast) begin
          state_d  = GS_PLAY;
          invuln_d = InvulnInit;
        end
      end
      GS_OVER, GS_WON: begin
        if (start_pulse) begin
          state_d = GS_IDLE;
          lives_d = LivesInit;
        end
      end
      default: state_d = GS_IDLE;
    endcase

    if (state_d != state_q) begin
      frame_cnt_d = 8'd0;
    end else if (frame_tick) begin
      frame_cnt_d = frame_cnt_q + 8'd1;
    end else begin
      frame_cnt_d = frame_cnt_q;
    end
  end

  // Outputs are registered from next-state values so they line up with the new state.
  always_ff @(posedge sys_clk or posedge Reset) begin
    if (Reset) begin
      state_q     <= GS_IDLE;
      frame_cnt_q <= 8'd0;
      invuln_q    <= 8'd0;
      lives_q     <= LivesInit;
      play_en     <= 1'b0;
      respawn     <= 1'b0;
      flash       <= 1'b0;
      game_over   <= 1'b0;
      game_won    <= 1'b0;
    end else begin
      state_q     <= state_d;
      frame_cnt_q <= frame_cnt_d;
      invuln_q    <= invuln_d;
      lives_q     <= lives_d;
      play_en     <= (state_d == GS_PLAY);
      respawn     <= respawn_d;
      flash       <= (state_d == GS_DYING) & frame_cnt_d[FLASH_SHIFT];
      game_over   <= (state_d == GS_OVER);
      game_won    <= (state_d == GS_WON);
    end
  end

  assign lives = lives_q;
  assign state = state_q;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Scoreboard bench for game_flow_ctrl using short frame timings.
module tb_game_flow_ctrl;

  localparam int unsigned DeathFrames   = 4;
  localparam int unsigned RespawnFrames = 3;
  localparam int unsigned InvulnFrames  = 5;

  logic       sys_clk = 1'b0;
  logic       Reset;
  logic       vSync;
  logic       start_pulse;
  logic       death_signal;
  logic [5:0] enemy_alive;
  logic       play_en;
  logic       respawn;
  logic [1:0] lives;
  logic       flash;
  logic       game_over;
  logic       game_won;
  logic [2:0] state;

  game_flow_ctrl #(
    .LIVES          (3),
    .DEATH_FRAMES   (DeathFrames),
    .RESPAWN_FRAMES (RespawnFrames),
    .INVULN_FRAMES  (InvulnFrames),
    .FLASH_SHIFT    (1)
  ) dut (
    .sys_clk      (sys_clk),
    .Reset        (Reset),
    .vSync        (vSync),
    .start_pulse  (start_pulse),
    .death_signal (death_signal),
    .enemy_alive  (enemy_alive),
    .play_en      (play_en),
    .respawn      (respawn),
    .lives        (lives),
    .flash        (flash),
    .game_over    (game_over),
    .game_won     (game_won),
    .state        (state)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    string      tag;
    logic [8:0] exp;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   resp_cnt = 0;
  int   rc;

  always @(negedge sys_clk) if (respawn === 1'b1) resp_cnt++;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Packed as {state, lives, play_en, flash, game_over, game_won}.
  task automatic push(input string tag, input logic [2:0] st, input logic [1:0] lv,
                      input logic pe, input logic fl, input logic ov, input logic wn);
    exp_t e;
    e.tag = tag;
    e.exp = {st, lv, pe, fl, ov, wn};
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check_val(e.tag, 32'({state, lives, play_en, flash, game_over, game_won}), 32'(e.exp));
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic frames(input int n);
    repeat (n) begin
      vSync = 1'b0;
      step(2);
      vSync = 1'b1;
      step(2);
    end
  endtask

  task automatic pulse_start();
    start_pulse = 1'b1;
    step(1);
    start_pulse = 1'b0;
  endtask

  task automatic pulse_death();
    death_signal = 1'b1;
    step(1);
    death_signal = 1'b0;
  endtask

  logic dying_flash[3] = '{1'b0, 1'b1, 1'b1};

  initial begin
    Reset        = 1'b1;
    vSync        = 1'b1;
    start_pulse  = 1'b0;
    death_signal = 1'b0;
    enemy_alive  = 6'h3F;
    step(2);
    push("reset", 3'd0, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    drain();
    check_val("reset_respawn", 32'(respawn), 32'd0);
    Reset = 1'b0;
    step(2);

    // Start a game.
    rc = resp_cnt;
    pulse_start();
    push("start_play", 3'd1, 2'd3, 1'b1, 1'b0, 1'b0, 1'b0);
    drain();
    step(2);
    check_val("start_respawn_once", 32'(resp_cnt - rc), 32'd1);

    // First death and full dying/respawn sequence.
    pulse_death();
    push("death1_dying", 3'd2, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0);
    drain();
    for (int i = 0; i < 3; i++) begin
      frames(1);
      push($sformatf("dying_frame%0d", i + 1), 3'd2, 2'd2, 1'b0, dying_flash[i], 1'b0, 1'b0);
      drain();
    end
    rc = resp_cnt;
    frames(1);
    push("dying_to_respawn", 3'd3, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0);
    drain();
    check_val("respawn_pulse_once", 32'(resp_cnt - rc), 32'd1);
    frames(RespawnFrames - 1);
    push("respawn_hold", 3'd3, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0);
    drain();
    frames(1);
    push("respawn_to_play", 3'd1, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0);
    drain();

    // Invulnerability window.
    frames(2);
    pulse_death();
    push("invuln_ignored", 3'd1, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0);
    drain();
    frames(4);
    pulse_death();
    push("death2_dying", 3'd2, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    drain();

    // Third death leads to game over.
    frames(DeathFrames + RespawnFrames);
    push("play_after_death2", 3'd1, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0);
    drain();
    frames(InvulnFrames);
    pulse_death();
    push("death3_dying", 3'd2, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    drain();
    rc = resp_cnt;
    frames(DeathFrames);
    push("game_over", 3'd4, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    drain();
    check_val("over_no_respawn", 32'(resp_cnt - rc), 32'd0);
    pulse_start();
    push("over_to_idle", 3'd0, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    drain();

    // Win, then death racing the win.
    pulse_start();
    enemy_alive = 6'b000001;
    step(1);
    push("one_enemy_left", 3'd1, 2'd3, 1'b1, 1'b0, 1'b0, 1'b0);
    drain();
    enemy_alive = 6'b000000;
    step(1);
    push("game_won", 3'd5, 2'd3, 1'b0, 1'b0, 1'b0, 1'b1);
    drain();
    enemy_alive = 6'b000001;
    pulse_start();
    push("won_to_idle", 3'd0, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    drain();
    pulse_start();
    death_signal = 1'b1;
    enemy_alive  = 6'b000000;
    step(1);
    death_signal = 1'b0;
    enemy_alive  = 6'h3F;
    push("death_beats_win", 3'd2, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0);
    drain();

    // Asynchronous reset mid-dying.
    frames(2);
    push("dying_before_reset", 3'd2, 2'd2, 1'b0, 1'b1, 1'b0, 1'b0);
    drain();
    rc = resp_cnt;
    Reset = 1'b1;
    #1;
    push("async_reset", 3'd0, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    drain();
    step(2);
    Reset = 1'b0;
    step(2);
    check_val("reset_no_respawn", 32'(resp_cnt - rc), 32'd0);

    // start_pulse ignored in RESPAWN.
    pulse_start();
    pulse_death();
    frames(DeathFrames);
    pulse_start();
    push("start_in_respawn", 3'd3, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0);
    drain();
    frames(RespawnFrames);
    push("resume_play", 3'd1, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
